// File: rtl/cc_coef_loader_pkg.sv
// Sequencer state and step encoding for the coefficient loader.
package cc_coef_loader_pkg;
  import color_corrector_csr_pkg::*;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA, ST_DONE
  } state_e;

  // One entry per transaction kind in the load/verify sequence.
  typedef enum logic [2:0] {
    STEP_LOCK, STEP_SEL, STEP_COEF, STEP_UNLOCK, STEP_VSEL, STEP_VRD
  } step_e;

  function automatic logic [31:0] step_word(step_e s);
    logic [31:0] w;
    unique case (s)
      STEP_LOCK, STEP_UNLOCK: w = 32'(COEF_LOCK_CR);
      STEP_SEL, STEP_VSEL:    w = 32'(COEF_SEL_CR);
      STEP_COEF:              w = 32'(COEF_CR);
      default:                w = 32'(CUR_COEF_SR);
    endcase
    return w;
  endfunction

  function automatic logic step_is_rd(step_e s);
    return s == STEP_VRD;
  endfunction
endpackage

// File: rtl/color_corrector_csr_pkg.sv
// Register word indices of the color corrector CSR block, shared by
// the CSR slave and every initiator that programs it.
package color_corrector_csr_pkg;
  localparam int unsigned COEF_LOCK_CR = 0;
  localparam int unsigned COEF_SEL_CR  = 1;
  localparam int unsigned COEF_CR      = 2;
  localparam int unsigned CUR_COEF_SR  = 3;
endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle, 32-bit address and data.
interface axi4_lite_if;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_single_txn.sv
// Single-outstanding AXI4-Lite initiator: one write or read per i_req,
// o_done pulses in the cycle of the B or R handshake.
module axi4_lite_single_txn (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_req,
  input  logic        i_rd,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_issued,
  output logic        o_done,
  output logic [1:0]  o_resp,
  output logic [31:0] o_rdata,
  axi4_lite_if.master m
);
  logic        r_awvalid, r_wvalid, r_arvalid, r_wr_pend, r_rd_pend;
  logic [31:0] r_awaddr, r_wdata, r_araddr;
  logic        w_aw_left, w_w_left, w_ar_left;
  logic        w_wr_issued, w_rd_issued, w_b_hs, w_r_hs;

  // A response is accepted as soon as all request channels are handshaken
  // by the end of this cycle, so B/R may coincide with the last AW/W/AR.
  assign w_aw_left   = r_awvalid & ~m.awready;
  assign w_w_left    = r_wvalid  & ~m.wready;
  assign w_ar_left   = r_arvalid & ~m.arready;
  assign w_wr_issued = r_wr_pend & ~w_aw_left & ~w_w_left;
  assign w_rd_issued = r_rd_pend & ~w_ar_left;
  assign w_b_hs      = w_wr_issued & m.bvalid;
  assign w_r_hs      = w_rd_issued & m.rvalid;

  assign o_issued = w_wr_issued | w_rd_issued;
  assign o_done   = w_b_hs | w_r_hs;
  assign o_resp   = w_r_hs ? m.rresp : m.bresp;
  assign o_rdata  = m.rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_wr_pend <= 1'b0;
      r_rd_pend <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_araddr  <= '0;
    end else begin
      if (m.awready) r_awvalid <= 1'b0;
      if (m.wready)  r_wvalid  <= 1'b0;
      if (m.arready) r_arvalid <= 1'b0;
      if (w_b_hs)    r_wr_pend <= 1'b0;
      if (w_r_hs)    r_rd_pend <= 1'b0;
      if (i_req) begin
        if (i_rd) begin
          r_arvalid <= 1'b1;
          r_araddr  <= i_addr;
          r_rd_pend <= 1'b1;
        end else begin
          r_awvalid <= 1'b1;
          r_wvalid  <= 1'b1;
          r_awaddr  <= i_addr;
          r_wdata   <= i_wdata;
          r_wr_pend <= 1'b1;
        end
      end
    end
  end

  assign m.awvalid = r_awvalid;
  assign m.awaddr  = r_awaddr;
  assign m.awprot  = 3'b000;
  assign m.wvalid  = r_wvalid;
  assign m.wdata   = r_wdata;
  assign m.wstrb   = 4'hF;
  assign m.bready  = 1'b1;
  assign m.arvalid = r_arvalid;
  assign m.araddr  = r_araddr;
  assign m.arprot  = 3'b000;
  assign m.rready  = 1'b1;
endmodule

// File: rtl/cc_coef_loader.sv
// Programs a full coefficient set into the color corrector CSR block:
// lock, (select, write) per coefficient, unlock, optional read-back verify.
module cc_coef_loader
  import cc_coef_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned COEF_CNT  = 12,
  parameter bit          VERIFY_EN = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [COEF_CNT-1:0][31:0] coef_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  axi4_lite_if.master              csr_o
);
  localparam logic [3:0] LAST_IDX = 4'(COEF_CNT - 1);

  state_e                     r_state, w_state_nxt;
  step_e                      r_step, w_step_nxt, w_adv_step;
  logic [3:0]                 r_idx, w_idx_nxt, w_adv_idx;
  logic [COEF_CNT-1:0][31:0]  r_coef;
  logic                       r_err;
  logic                       w_adv_last, w_req, w_req_rd;
  logic [31:0]                w_req_addr, w_req_wdata, w_rdata;
  logic                       w_issued, w_done;
  logic [1:0]                 w_resp;

  // Successor of the transaction currently in flight.
  always_comb begin
    w_adv_step = r_step;
    w_adv_idx  = r_idx;
    w_adv_last = 1'b0;
    unique case (r_step)
      STEP_LOCK: begin w_adv_step = STEP_SEL; w_adv_idx = '0; end
      STEP_SEL:  w_adv_step = STEP_COEF;
      STEP_COEF: begin
        if (r_idx == LAST_IDX) begin w_adv_step = STEP_UNLOCK; w_adv_idx = '0; end
        else begin w_adv_step = STEP_SEL; w_adv_idx = r_idx + 4'd1; end
      end
      STEP_UNLOCK: begin
        if (VERIFY_EN) begin w_adv_step = STEP_VSEL; w_adv_idx = '0; end
        else w_adv_last = 1'b1;
      end
      STEP_VSEL: w_adv_step = STEP_VRD;
      default: begin
        if (r_idx == LAST_IDX) w_adv_last = 1'b1;
        else begin w_adv_step = STEP_VSEL; w_adv_idx = r_idx + 4'd1; end
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_idx_nxt   = r_idx;
    w_req       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_req       = 1'b1;
          w_step_nxt  = STEP_LOCK;
          w_idx_nxt   = '0;
          w_state_nxt = ST_WR;
        end
      end
      ST_WR:      if (w_issued) w_state_nxt = ST_WR_RESP;
      ST_RD_ADDR: if (w_issued) w_state_nxt = ST_RD_DATA;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default: ;
    endcase
    // Completion launches the next transaction in the same cycle.
    if (w_done && r_state != ST_IDLE && r_state != ST_DONE) begin
      if (w_adv_last) begin
        w_state_nxt = ST_DONE;
      end else begin
        w_req       = 1'b1;
        w_step_nxt  = w_adv_step;
        w_idx_nxt   = w_adv_idx;
        w_state_nxt = step_is_rd(w_adv_step) ? ST_RD_ADDR : ST_WR;
      end
    end
  end

  always_comb begin
    w_req_rd    = step_is_rd(w_step_nxt);
    w_req_addr  = BASE_ADDR + (step_word(w_step_nxt) << 2);
    w_req_wdata = '0;
    unique case (w_step_nxt)
      STEP_LOCK:           w_req_wdata = 32'd1;
      STEP_SEL, STEP_VSEL: w_req_wdata = {28'd0, w_idx_nxt};
      STEP_COEF:           w_req_wdata = r_coef[w_idx_nxt];
      default:             w_req_wdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_step  <= STEP_LOCK;
      r_idx   <= '0;
      r_coef  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_idx   <= w_idx_nxt;
      if (r_state == ST_IDLE && start_i) begin
        r_coef <= coef_i;
        r_err  <= 1'b0;
      end else if (w_done && (w_resp != 2'b00 ||
                   (r_step == STEP_VRD && w_rdata != r_coef[r_idx]))) begin
        r_err <= 1'b1;
      end
    end
  end

  axi4_lite_single_txn u_txn (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_req    (w_req),
    .i_rd     (w_req_rd),
    .i_addr   (w_req_addr),
    .i_wdata  (w_req_wdata),
    .o_issued (w_issued),
    .o_done   (w_done),
    .o_resp   (w_resp),
    .o_rdata  (w_rdata),
    .m        (csr_o)
  );

  assign busy_o = (r_state != ST_IDLE);
  assign done_o = (r_state == ST_DONE);
  assign err_o  = r_err;
endmodule

// File: tb/tb_cc_coef_loader.sv
// Randomized bench: CSR slave model with random stalls, expected transaction
// list built straight from the load/verify sequence rules.
module tb_cc_coef_loader;
  import color_corrector_csr_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0100;
  localparam int N   = 12;
  localparam int TMO = 4000;

  typedef struct { bit rd; logic [31:0] addr; logic [31:0] data; } txn_t;

  logic clk = 1'b0;
  logic rst, start, busy, done, err;
  logic [N-1:0][31:0] coef;
  axi4_lite_if bus();

  cc_coef_loader #(.BASE_ADDR(BASE), .COEF_CNT(N), .VERIFY_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .coef_i(coef),
    .busy_o(busy), .done_o(done), .err_o(err), .csr_o(bus)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // slave configuration and observed state
  int          maxd = 0, corrupt_sel = -1, cyc = 0, last_hs = 0;
  bit          split = 0, berr_arm = 0;
  txn_t        log_q[$], exp_q[$];
  logic [31:0] mem [16];
  logic        lock = 1'b0;
  logic [3:0]  sel = '0;

  initial begin
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, idx;
    bit aw_got, w_got, b_pend, r_pend;
    logic [31:0] aw_a, w_d, r_d;
    logic [1:0]  b_r;
    logic s_rst, s_awv, s_awr, s_wv, s_wr, s_bv, s_br, s_arv, s_arr, s_rv, s_rr;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic p_rst, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    p_rst = 1; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    p_awaddr = 0; p_wdata = 0; p_araddr = 0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; b_r = 0; r_d = 0; aw_a = 0; w_d = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
    forever begin
      @(posedge clk);
      cyc++;
      s_rst = rst;
      s_awv = bus.awvalid; s_awr = bus.awready; s_awaddr = bus.awaddr;
      s_wv = bus.wvalid; s_wr = bus.wready; s_wdata = bus.wdata;
      s_bv = bus.bvalid; s_br = bus.bready;
      s_arv = bus.arvalid; s_arr = bus.arready; s_araddr = bus.araddr;
      s_rv = bus.rvalid; s_rr = bus.rready;
      if (!p_rst && !s_rst) begin
        chk("aw_ar_excl", 96'(s_awv & s_arv), 96'd0);
        if (p_awv && !p_awr) chk("aw_hold", {s_awv, s_awaddr}, {1'b1, p_awaddr});
        if (p_wv && !p_wr)   chk("w_hold", {s_wv, s_wdata}, {1'b1, p_wdata});
        if (p_arv && !p_arr) chk("ar_hold", {s_arv, s_araddr}, {1'b1, p_araddr});
      end
      p_rst = s_rst; p_awv = s_awv; p_awr = s_awr; p_awaddr = s_awaddr;
      p_wv = s_wv; p_wr = s_wr; p_wdata = s_wdata; p_arv = s_arv; p_arr = s_arr; p_araddr = s_araddr;
      #1;
      if (s_rst) begin
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.arready = 0; bus.rvalid = 0;
        aw_cnt = $urandom_range(0, maxd);
        w_cnt = split ? aw_cnt + 3 : $urandom_range(0, maxd);
        ar_cnt = $urandom_range(0, maxd);
      end else begin
        if (s_awv && s_awr) begin
          aw_got = 1; aw_a = s_awaddr;
          chk("awprot", 96'(bus.awprot), 96'd0);
        end
        if (s_wv && s_wr) begin
          w_got = 1; w_d = s_wdata;
          chk("wstrb", 96'(bus.wstrb), 96'hF);
        end
        if (s_bv && s_br) begin bus.bvalid = 0; last_hs = cyc; end
        if (s_rv && s_rr) begin bus.rvalid = 0; last_hs = cyc; end
        if (s_arv && s_arr) begin
          log_q.push_back('{1'b1, s_araddr, 32'd0});
          chk("arprot", 96'(bus.arprot), 96'd0);
          r_d = mem[sel] ^ ((int'(sel) == corrupt_sel) ? 32'd1 : 32'd0);
          r_pend = 1; r_cnt = $urandom_range(0, maxd); ar_cnt = $urandom_range(0, maxd);
        end
        if (aw_got && w_got) begin
          log_q.push_back('{1'b0, aw_a, w_d});
          idx = int'((aw_a - BASE) >> 2);
          b_r = 2'b00;
          if (idx == int'(COEF_LOCK_CR)) lock = w_d[0];
          else if (idx == int'(COEF_SEL_CR)) begin
            sel = w_d[3:0];
            if (berr_arm && w_d == 32'd3) begin b_r = 2'b10; berr_arm = 0; end
          end else if (idx == int'(COEF_CR)) mem[sel] = w_d;
          b_pend = 1; b_cnt = $urandom_range(0, maxd);
          aw_got = 0; w_got = 0;
          aw_cnt = $urandom_range(0, maxd);
          w_cnt = split ? aw_cnt + 3 : $urandom_range(0, maxd);
        end
        if (b_pend) begin
          if (b_cnt == 0) begin bus.bvalid = 1; bus.bresp = b_r; b_pend = 0; end
          else b_cnt--;
        end
        if (r_pend) begin
          if (r_cnt == 0) begin bus.rvalid = 1; bus.rdata = r_d; bus.rresp = 0; r_pend = 0; end
          else r_cnt--;
        end
        if (bus.awvalid && aw_cnt > 0) aw_cnt--;
        if (bus.wvalid && w_cnt > 0) w_cnt--;
        if (bus.arvalid && ar_cnt > 0) ar_cnt--;
        bus.awready = bus.awvalid && aw_cnt == 0;
        bus.wready  = bus.wvalid && w_cnt == 0;
        bus.arready = bus.arvalid && ar_cnt == 0;
      end
    end
  end

  task automatic push_exp(input bit rd, input int unsigned word, input logic [31:0] d);
    exp_q.push_back('{rd, BASE + 32'(word << 2), d});
  endtask

  task automatic run(input logic [N-1:0][31:0] c, input bit exp_err, input bit mid);
    int k;
    bit seen;
    exp_q.delete();
    push_exp(0, COEF_LOCK_CR, 32'd1);
    for (int i = 0; i < N; i++) begin
      push_exp(0, COEF_SEL_CR, 32'(i));
      push_exp(0, COEF_CR, c[i]);
    end
    push_exp(0, COEF_LOCK_CR, 32'd0);
    for (int i = 0; i < N; i++) begin
      push_exp(0, COEF_SEL_CR, 32'(i));
      push_exp(1, CUR_COEF_SR, 32'd0);
    end
    log_q.delete();
    @(negedge clk); start = 1; coef = c;
    @(posedge clk); #1;
    chk("busy_t1", 96'(busy), 96'd1);
    chk("awwvalid_t1", 96'(bus.awvalid & bus.wvalid), 96'd1);
    chk("err_clr", 96'(err), 96'd0);
    @(negedge clk); start = 0;
    for (int i = 0; i < N; i++) coef[i] = $urandom;
    seen = 0; k = 0;
    while (!seen && k < TMO) begin
      if (mid && k == 20) begin start = 1; coef = ~c; end
      else start = 0;
      @(negedge clk); k++;
      if (done) seen = 1;
    end
    start = 0;
    chk("done_seen", 96'(seen), 96'd1);
    if (seen) begin
      chk("done_lat", 96'(cyc), 96'(last_hs));
      chk("busy_at_done", 96'(busy), 96'd1);
      chk("err", 96'(err), 96'(exp_err));
      @(negedge clk);
      chk("busy_fall", 96'(busy), 96'd0);
      chk("done_pulse", 96'(done), 96'd0);
    end
    chk("ntxn", 96'(log_q.size()), 96'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("txn%0d", i), {log_q[i].rd, log_q[i].addr, log_q[i].data},
          {exp_q[i].rd, exp_q[i].addr, exp_q[i].data});
    chk("unlocked", 96'(lock), 96'd0);
  endtask

  task automatic rand_coef(output logic [N-1:0][31:0] c);
    for (int i = 0; i < N; i++) c[i] = $urandom;
  endtask

  task automatic mid_reset();
    logic [N-1:0][31:0] c;
    bit found;
    rand_coef(c);
    log_q.delete();
    @(negedge clk); start = 1; coef = c;
    @(negedge clk); start = 0;
    found = 0;
    for (int k = 0; k < TMO && !found; k++) begin
      if (busy && !bus.awvalid && !bus.wvalid && !bus.arvalid && !bus.bvalid &&
          log_q.size() >= 3 && !log_q[log_q.size()-1].rd) found = 1;
      else @(negedge clk);
    end
    chk("rst_window", 96'(found), 96'd1);
    rst = 1;
    @(negedge clk); rst = 0;
    chk("rst_valids", {93'd0, bus.awvalid, bus.wvalid, bus.arvalid}, 96'd0);
    chk("rst_busy", 96'(busy), 96'd0);
    chk("rst_done", 96'(done), 96'd0);
    rand_coef(c);
    run(c, 0, 0);
  endtask

  initial begin
    logic [N-1:0][31:0] c;
    rst = 1; start = 0; coef = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_awvalid", 96'(bus.awvalid), 96'd0);
    chk("rst_wvalid", 96'(bus.wvalid), 96'd0);
    chk("rst_arvalid", 96'(bus.arvalid), 96'd0);
    chk("rst_readies", {94'd0, bus.bready, bus.rready}, 96'd3);
    chk("rst_addr_data", {bus.awaddr, bus.wdata, bus.araddr}, 96'd0);
    chk("rst_flags", {93'd0, busy, done, err}, 96'd0);
    @(negedge clk); rst = 0;

    rand_coef(c); run(c, 0, 0);
    maxd = 7;
    for (int i = 0; i < N; i++) c[i] = 32'h1000_0000 + 32'(i);
    run(c, 0, 0);
    corrupt_sel = 5; run(c, 1, 0); corrupt_sel = -1;
    maxd = 3; berr_arm = 1;
    rand_coef(c); run(c, 1, 0);
    chk("berr_used", 96'(berr_arm), 96'd0);
    rand_coef(c); run(c, 0, 0);
    split = 1; maxd = 7;
    rand_coef(c); run(c, 0, 0);
    split = 0; maxd = 2;
    rand_coef(c); run(c, 0, 1);
    maxd = 5;
    mid_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cc_coef_loader.md
# cc_coef_loader

AXI4-Lite initiator that programs a full color-correction coefficient set into the color corrector CSR block. On a start pulse it latches a coefficient table, then drives a fixed transaction sequence: lock, per-coefficient select and write, unlock, optional read-back verify. It sits between the system controller (or a frame-sync scheduler) and the color corrector's CSR slave port. Coefficient updates therefore need no software register poking.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte base address of the target color corrector CSR block.
- `COEF_CNT`, default 12: number of coefficients written, indices 0..COEF_CNT-1; legal range 1..16, limited by the 4-bit select register.
- `VERIFY_EN`, default 1: 1 enables the read-back verify pass.
- `clk_i` input 1: single clock.
- `rst_i` input 1: reset. Synchronous, active-high.
- `start_i` input 1: start request, sampled only in IDLE.
- `coef_i` input [COEF_CNT-1:0][31:0]: coefficient table, latched on an accepted start.
- `busy_o` output 1: high from the cycle after an accepted start through the cycle of `done_o`.
- `done_o` output 1: one-cycle completion pulse.
- `err_o` output 1: sticky error flag; cleared on the next accepted start.
- `csr_o` axi4_lite_if.master: AXI4-Lite initiator port.

## Operation
- **Register map.** Word indices come from the shared package: COEF_LOCK_CR=0, COEF_SEL_CR=1, COEF_CR=2, CUR_COEF_SR=3. Byte address = BASE_ADDR + (index << 2).
- **Write sequence.**
  - W(LOCK, 1).
  - For i = 0..COEF_CNT-1: W(SEL, i), then W(COEF, coef[i]).
  - W(LOCK, 0).
- **Verify pass** (VERIFY_EN=1): for i = 0..COEF_CNT-1, W(SEL, i) then R(CUR_COEF). Compare the read data with coef[i]; a mismatch sets `err_o`.
- **Write transaction.**
  - `awvalid` and `wvalid` assert in the same cycle. Each deasserts independently on its own handshake.
  - `wstrb`=4'hF. `awprot`/`arprot`=0.
  - The transaction completes on the B handshake. `bready` is held 1.
- **Read transaction.**
  - `arvalid` is held until `arready`. `rready` is held 1.
  - `rdata` and `rresp` are captured on the R handshake.
- **Errors.** `bresp` or `rresp` != 2'b00 sets `err_o`. The sequence continues to completion so that LOCK is always released.
- **FSM states:** IDLE, WR (AW/W outstanding), WR_RESP, RD_ADDR, RD_DATA, DONE.
- **Step counter.** A step counter plus a coefficient index select the address and data of the next transaction.
  - WR → WR_RESP when both AW and W have handshaken. The two may handshake in different cycles.
  - WR_RESP → next step on B handshake.
  - RD_ADDR → RD_DATA on `arready`.
  - RD_DATA → next step on R handshake.
  - DONE → IDLE after one cycle.
- **Start while busy:** `start_i` outside IDLE is ignored.
- **Reset values:** all valids 0, `bready`/`rready` 1, addresses and data 0, `busy_o`/`done_o`/`err_o` 0, state IDLE, counters 0.

## Timing
- `start_i` sampled high in IDLE at cycle t: `coef_i` is latched at t. At t+1, `busy_o`=1 and the first AW/W valids are asserted.
- The next transaction's valids assert in the cycle after the previous B/R handshake. There is no idle gap beyond that.
- Exactly one transaction is outstanding at a time. AW and AR are never both valid.
- **Valid stability:** `awaddr`/`wdata`/`araddr` stay stable while their valid is high. No valid drops without a handshake, except on reset.
- **Completion:** `done_o` is high in the cycle after the last handshake. `busy_o` falls the following cycle.
- **Transaction count:** 2·COEF_CNT+2 writes, plus 2·COEF_CNT when verify is enabled.
- **Reset mid-sequence:** all valids drop the next edge. There is no unlock attempt; software re-runs the load.
- **Response before valid drops:** a B or R response arriving in the same cycle its valid deasserts is still accepted.

## Structure
- Register index constants come from the shared color_corrector_csr_pkg; no duplicates.
- A new shared package entry defines the FSM state enum and the step encoding.
- One natural sub-module, `axi4_lite_single_txn`:
  - Handles one write or read: request, address, data, done and response.
  - Is reusable by other loaders.
  - Leaves the sequencer in the top module.

## Test plan
- **Nominal, single-cycle slave:** COEF_CNT=12, VERIFY_EN=0, slave always ready. Expect 26 writes in order: LOCK=1, (SEL=i, COEF=coef[i]) ×12, LOCK=0. `done_o` pulses once; `err_o`=0.
- **Verify pass against the real CSR slave:** coefficients = 32'h1000_0000+i.
  - All 12 read-backs match and `err_o`=0.
  - Corrupt the read data for i=5: `err_o`=1 and the sequence still ends with LOCK=0.
- **Split handshakes:** randomized `awready`/`wready`/`bvalid` delays of 0..7 cycles, with AW accepted 3 cycles before W. Each address/data pair is unchanged until its handshake; the same sequence results.
- **Error response:** `bresp`=2'b10 on the W(SEL, 3) transaction sets `err_o`=1. All remaining writes are still issued. The next start clears `err_o`.
- **Start while busy:** a `start_i` pulse mid-sequence with a changed `coef_i` does not alter the writes in progress.
- **Reset mid-sequence:** `rst_i` for one cycle during WR_RESP. The next cycle shows all valids 0, `busy_o`=0 and IDLE; a new start runs the full sequence.
